// File: rtl/i2c_req_arbiter_if.sv
// Requester and i2c_master command-port bundle for i2c_req_arbiter.
// slave modport is the arbiter's view; master modport is the environment's view.
interface i2c_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_rw;
  logic [7*NREQ-1:0]    req_slave_addr;
  logic [32*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_wr_data;
  logic [NREQ-1:0]      req_i2aen;
  logic [2*NREQ-1:0]    req_i2ac;
  logic [2*NREQ-1:0]    req_i2dc;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          rsp_rd_data;
  logic [NREQ-1:0]      rsp_rd_valid;
  logic [NREQ-1:0]      rsp_done;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 m_valid;
  logic                 m_rw;
  logic [6:0]           m_slave_addr;
  logic [31:0]          m_addr;
  logic [31:0]          m_wr_data;
  logic                 m_i2aen;
  logic [1:0]           m_i2ac;
  logic [1:0]           m_i2dc;
  logic                 m_stall;
  logic [31:0]          m_rd_data;
  logic                 m_rd_valid;

  modport slave (
    input  req_valid, req_rw, req_slave_addr, req_addr, req_wr_data,
           req_i2aen, req_i2ac, req_i2dc, m_stall, m_rd_data, m_rd_valid,
    output req_ready, rsp_rd_data, rsp_rd_valid, rsp_done, busy, grant_id,
           m_valid, m_rw, m_slave_addr, m_addr, m_wr_data, m_i2aen, m_i2ac, m_i2dc
  );

  modport master (
    output req_valid, req_rw, req_slave_addr, req_addr, req_wr_data,
           req_i2aen, req_i2ac, req_i2dc, m_stall, m_rd_data, m_rd_valid,
    input  req_ready, rsp_rd_data, rsp_rd_valid, rsp_done, busy, grant_id,
           m_valid, m_rw, m_slave_addr, m_addr, m_wr_data, m_i2aen, m_i2ac, m_i2dc
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between NREQ requesters.
// Define I2C_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module i2c_req_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               hclk,
  input  logic               hresetn,
  i2c_req_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {ARB, ISSUE, WAIT_START, BUSY, DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  winner;
  logic            any_req;
  logic            m_valid_q;
  logic            busy_q;
  logic [NREQ-1:0] done_q;

  logic            c_rw;
  logic [6:0]      c_sa;
  logic [31:0]     c_addr;
  logic [31:0]     c_wd;
  logic            c_aen;
  logic [1:0]      c_ac;
  logic [1:0]      c_dc;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
    int unsigned s;
    s = (32'(base) + k) % NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    winner  = '0;
    any_req = |bus.req_valid;
`ifdef I2C_ARB_FIXED_PRI_EN
    for (int unsigned k = NREQ; k > 0; k--)
      if (bus.req_valid[IDW'(k-1)]) winner = IDW'(k-1);
`else
    // Scan farthest-to-nearest from last_grant so the nearest pending requester wins.
    for (int unsigned k = NREQ; k > 0; k--)
      if (bus.req_valid[rr_idx(last_grant, k)]) winner = rr_idx(last_grant, k);
`endif
  end

  always_comb begin
    bus.req_ready = '0;
    if (hresetn && state == ARB && any_req) bus.req_ready[winner] = 1'b1;
  end

  always_comb begin
    bus.rsp_rd_valid = '0;
    if (bus.m_rd_valid && (state == WAIT_START || state == BUSY))
      bus.rsp_rd_valid[grant_q] = 1'b1;
  end

  assign bus.rsp_rd_data  = bus.m_rd_data;
  assign bus.rsp_done     = done_q;
  assign bus.busy         = busy_q;
  assign bus.grant_id     = grant_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_rw         = c_rw;
  assign bus.m_slave_addr = c_sa;
  assign bus.m_addr       = c_addr;
  assign bus.m_wr_data    = c_wd;
  assign bus.m_i2aen      = c_aen;
  assign bus.m_i2ac       = c_ac;
  assign bus.m_i2dc       = c_dc;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= ARB;
      last_grant <= IDW'(NREQ-1);
      grant_q    <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      c_rw       <= 1'b0;
      c_sa       <= '0;
      c_addr     <= '0;
      c_wd       <= '0;
      c_aen      <= 1'b0;
      c_ac       <= '0;
      c_dc       <= '0;
    end else begin
      done_q <= '0;
      unique case (state)
        ARB: begin
          if (any_req) begin
            c_rw       <= bus.req_rw[winner];
            c_sa       <= bus.req_slave_addr[7*winner +: 7];
            c_addr     <= bus.req_addr[32*winner +: 32];
            c_wd       <= bus.req_wr_data[32*winner +: 32];
            c_aen      <= bus.req_i2aen[winner];
            c_ac       <= bus.req_i2ac[2*winner +: 2];
            c_dc       <= bus.req_i2dc[2*winner +: 2];
            grant_q    <= winner;
            last_grant <= winner;
            m_valid_q  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.m_stall) begin
            m_valid_q <= 1'b0;
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (bus.m_stall) state <= BUSY;
        end
        BUSY: begin
          if (!bus.m_stall) begin
            done_q[grant_q] <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter with a simple stalling i2c_master model.
module tb_i2c_req_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic hclk;
  logic hresetn;

  i2c_req_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  i2c_req_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stab_err = 0;
  int oh_err   = 0;
  int rem [NREQ];

  logic [NREQ-1:0] ack;
  logic [76:0]     cap_cmd;
  logic [76:0]     cur_cmd;
  logic [31:0]     slave_data;

  int grant_log[$];
  int done_log[$];
  int done_cyc[$];
  int rd_log[$];
  int rd_cyc[$];
  logic [31:0] rd_data_log[$];

  // Master model: accepts on valid & !stall, stalls for a fixed length, returns one read word.
  logic [3:0] mcnt;
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bus.m_stall    <= 1'b0;
      bus.m_rd_valid <= 1'b0;
      bus.m_rd_data  <= '0;
      mcnt           <= '0;
    end else begin
      bus.m_rd_valid <= 1'b0;
      if (!bus.m_stall) begin
        if (bus.m_valid) begin
          bus.m_stall <= 1'b1;
          mcnt        <= 4'd5;
        end
      end else begin
        if (mcnt == 4'd0) bus.m_stall <= 1'b0;
        else mcnt <= mcnt - 4'd1;
        if (mcnt == 4'd2 && !bus.m_rw) begin
          bus.m_rd_valid <= 1'b1;
          bus.m_rd_data  <= slave_data;
        end
      end
    end
  end

  function automatic int first_set(input logic [NREQ-1:0] v);
    for (int i = NREQ-1; i >= 0; i--) if (v[i]) first_set = i;
  endfunction

  function automatic int unsigned enc(input int q[$]);
    int unsigned r;
    r = 0;
    foreach (q[k]) r = r * 16 + 32'(q[k] + 1);
    return r;
  endfunction

  task automatic tick();
    @(negedge hclk);
    cyc++;
    ack = bus.req_ready;
    cur_cmd = {bus.m_rw, bus.m_slave_addr, bus.m_addr, bus.m_wr_data,
               bus.m_i2aen, bus.m_i2ac, bus.m_i2dc};
    if (ack != '0) begin
      grant_log.push_back(first_set(ack));
      if ($countones(ack) != 1) oh_err++;
    end
    if (bus.rsp_done != '0) begin
      done_log.push_back(first_set(bus.rsp_done));
      done_cyc.push_back(cyc);
    end
    if (bus.rsp_rd_valid != '0) begin
      rd_log.push_back(first_set(bus.rsp_rd_valid));
      rd_cyc.push_back(cyc);
      rd_data_log.push_back(bus.rsp_rd_data);
    end
    if (bus.m_valid && !bus.m_stall) cap_cmd = cur_cmd;
    if (bus.m_stall && (bus.m_valid || cur_cmd != cap_cmd)) stab_err++;
    @(posedge hclk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (ack[i]) begin
        if (rem[i] > 0) rem[i]--;
        if (rem[i] == 0) bus.req_valid[i] = 1'b0;
      end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    grant_log.delete(); done_log.delete(); done_cyc.delete();
    rd_log.delete(); rd_cyc.delete(); rd_data_log.delete();
    stab_err = 0;
    oh_err   = 0;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [6:0] sa, input logic aen,
                         input logic [1:0] ac, input logic [31:0] addr, input logic [1:0] dc,
                         input logic [31:0] wd, input int count);
    bus.req_rw[i]               = rw;
    bus.req_slave_addr[7*i +: 7] = sa;
    bus.req_i2aen[i]            = aen;
    bus.req_i2ac[2*i +: 2]      = ac;
    bus.req_addr[32*i +: 32]    = addr;
    bus.req_i2dc[2*i +: 2]      = dc;
    bus.req_wr_data[32*i +: 32] = wd;
    rem[i]                      = count;
    bus.req_valid[i]            = 1'b1;
  endtask

  task automatic apply_reset();
    hresetn = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    run(2);
    hresetn = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    bus.req_valid      = '0;
    bus.req_rw         = '0;
    bus.req_slave_addr = '0;
    bus.req_addr       = '0;
    bus.req_wr_data    = '0;
    bus.req_i2aen      = '0;
    bus.req_i2ac       = '0;
    bus.req_i2dc       = '0;
    slave_data         = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    run(2);
    bus.req_valid[1] = 1'b1;
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b m_valid=%b expected 0 0", bus.busy, bus.m_valid);
    end
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_done !== '0 || bus.rsp_rd_valid !== '0) begin
      failures++;
      $display("FAIL reset_strobes ready=%b done=%b rdv=%b expected 0", bus.req_ready, bus.rsp_done, bus.rsp_rd_valid);
    end
    checks++;
    if (bus.grant_id !== '0 || {bus.m_rw, bus.m_slave_addr, bus.m_addr, bus.m_wr_data,
                                bus.m_i2aen, bus.m_i2ac, bus.m_i2dc} !== 77'd0) begin
      failures++;
      $display("FAIL reset_cmd grant_id=%0d m_addr=%h expected 0", bus.grant_id, bus.m_addr);
    end
    bus.req_valid = '0;
    run(1);
    hresetn = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_write();
    clear_logs();
    set_req(0, 1'b1, 7'h50, 1'b1, 2'd0, 32'h12, 2'd0, 32'hA5, 1);
    run(16);
    checks++;
    if (enc(grant_log) !== 32'h1 || oh_err != 0) begin
      failures++;
      $display("FAIL wr_grant seq=%h onehot_err=%0d expected 1 0", enc(grant_log), oh_err);
    end
    checks++;
    if (cap_cmd !== {1'b1, 7'h50, 32'h12, 32'hA5, 1'b1, 2'd0, 2'd0}) begin
      failures++;
      $display("FAIL wr_cmd got=%h", cap_cmd);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL wr_stable violations=%0d expected 0", stab_err);
    end
    checks++;
    if (enc(done_log) !== 32'h1 || rd_log.size() != 0) begin
      failures++;
      $display("FAIL wr_done seq=%h rd_cnt=%0d expected 1 0", enc(done_log), rd_log.size());
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
      failures++;
      $display("FAIL wr_idle busy=%b grant_id=%0d expected 0 0", bus.busy, bus.grant_id);
    end
  endtask

  task automatic test_single_read();
    clear_logs();
    slave_data = 32'hDEADBEEF;
    set_req(2, 1'b0, 7'h3C, 1'b1, 2'd1, 32'h1234, 2'd3, 32'h0, 1);
    run(16);
    checks++;
    if (enc(grant_log) !== 32'h3 || cap_cmd !== {1'b0, 7'h3C, 32'h1234, 32'h0, 1'b1, 2'd1, 2'd3}) begin
      failures++;
      $display("FAIL rd_grant seq=%h cmd=%h", enc(grant_log), cap_cmd);
    end
    checks++;
    if (enc(rd_log) !== 32'h3 || rd_data_log.size() != 1 || rd_data_log[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_data seq=%h cnt=%0d expected 3 1 deadbeef", enc(rd_log), rd_data_log.size());
    end
    checks++;
    if (enc(done_log) !== 32'h3 || rd_cyc.size() != 1 || done_cyc.size() != 1 || !(rd_cyc[0] < done_cyc[0])) begin
      failures++;
      $display("FAIL rd_order done_seq=%h rd_cnt=%0d done_cnt=%0d expected rd before done", enc(done_log), rd_cyc.size(), done_cyc.size());
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL rd_stable violations=%0d expected 0", stab_err);
    end
  endtask

  task automatic test_contention();
    int unsigned exp_seq;
    apply_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 7'(8'h10 + i), 1'b0, 2'd0, 32'(i), 2'd0, 32'(100 + i), (i == 0) ? 2 : 1);
    run(5 * 16);
`ifdef I2C_ARB_FIXED_PRI_EN
    exp_seq = 32'h11234;
`else
    exp_seq = 32'h12341;
`endif
    checks++;
    if (enc(grant_log) !== exp_seq) begin
      failures++;
      $display("FAIL cont_grant seq=%h expected %h", enc(grant_log), exp_seq);
    end
    checks++;
    if (enc(done_log) !== exp_seq || rd_log.size() != 0) begin
      failures++;
      $display("FAIL cont_done seq=%h expected %h", enc(done_log), exp_seq);
    end
    checks++;
    if (stab_err != 0 || oh_err != 0) begin
      failures++;
      $display("FAIL cont_overlap stab=%0d onehot=%0d expected 0 0", stab_err, oh_err);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    set_req(3, 1'b1, 7'h33, 1'b0, 2'd0, 32'h3, 2'd0, 32'h33, 1);
    run(16);
    set_req(1, 1'b1, 7'h11, 1'b0, 2'd0, 32'h1, 2'd0, 32'h11, 1);
    set_req(3, 1'b1, 7'h33, 1'b0, 2'd0, 32'h3, 2'd0, 32'h33, 1);
    run(32);
    checks++;
    if (enc(grant_log) !== 32'h424) begin
      failures++;
      $display("FAIL wrap_grant seq=%h expected 424", enc(grant_log));
    end
    checks++;
    if (bus.grant_id !== 2'd3 || enc(done_log) !== 32'h424) begin
      failures++;
      $display("FAIL wrap_done grant_id=%0d seq=%h expected 3 424", bus.grant_id, enc(done_log));
    end
  endtask

  task automatic test_priority_mode();
    int unsigned exp_seq;
    clear_logs();
    set_req(0, 1'b1, 7'h01, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 3);
    set_req(3, 1'b1, 7'h04, 1'b0, 2'd0, 32'h3, 2'd0, 32'h3, 3);
    run(6 * 16);
`ifdef I2C_ARB_FIXED_PRI_EN
    exp_seq = 32'h111444;
`else
    exp_seq = 32'h141414;
`endif
    checks++;
    if (enc(grant_log) !== exp_seq) begin
      failures++;
      $display("FAIL prio_grant seq=%h expected %h", enc(grant_log), exp_seq);
    end
  endtask

  task automatic test_reset_mid_busy();
    clear_logs();
    slave_data = 32'hCAFEF00D;
    set_req(2, 1'b0, 7'h22, 1'b1, 2'd0, 32'h2, 2'd3, 32'h0, 1);
    run(4);
    set_req(1, 1'b1, 7'h11, 1'b1, 2'd0, 32'h77, 2'd0, 32'h5A, 1);
    run(1);
    checks++;
    if (bus.busy !== 1'b1 || bus.m_stall !== 1'b1 || bus.grant_id !== 2'd2) begin
      failures++;
      $display("FAIL mid_pre busy=%b stall=%b grant_id=%0d expected 1 1 2", bus.busy, bus.m_stall, bus.grant_id);
    end
    #2;
    hresetn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.req_ready !== '0 ||
        bus.rsp_done !== '0 || bus.grant_id !== '0 || bus.m_addr !== '0) begin
      failures++;
      $display("FAIL mid_reset busy=%b m_valid=%b ready=%b grant_id=%0d m_addr=%h expected all 0",
               bus.busy, bus.m_valid, bus.req_ready, bus.grant_id, bus.m_addr);
    end
    run(2);
    clear_logs();
    hresetn = 1'b1;
    run(16);
    checks++;
    if (enc(grant_log) !== 32'h2 || enc(done_log) !== 32'h2 || rd_log.size() != 0) begin
      failures++;
      $display("FAIL mid_after grant=%h done=%h rd_cnt=%0d expected 2 2 0", enc(grant_log), enc(done_log), rd_log.size());
    end
    checks++;
    if (cap_cmd !== {1'b1, 7'h11, 32'h77, 32'h5A, 1'b1, 2'd0, 2'd0} || stab_err != 0) begin
      failures++;
      $display("FAIL mid_cmd cmd=%h stab=%0d", cap_cmd, stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_wrap();
    test_priority_mode();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
Round-robin arbiter that shares one i2c_master command port (valid/stall handshake) between NREQ independent requesters, e.g. the testbench host path and on-board config/poll engines. It accepts one complete I2C transaction from a requester and holds every master input stable until the master returns to idle. It then routes read data back and signals completion to the owner.

Parameters:
NREQ, 4, number of requesters (2..4)
IDW, 2, grant index width, >= clog2(NREQ)

Ports:
hclk  in  1  system clock
hresetn  in  1  async active-low reset
req_valid  in  NREQ  per-requester command pending; held until req_ready
req_rw  in  NREQ  1=write, 0=read
req_slave_addr  in  7*NREQ  7-bit slave address, slice i for requester i
req_addr  in  32*NREQ  register address bytes
req_wr_data  in  32*NREQ  write data
req_i2aen  in  NREQ  address phase enable
req_i2ac  in  2*NREQ  address bytes minus 1
req_i2dc  in  2*NREQ  data bytes minus 1
req_ready  out  NREQ  one-hot accept pulse
rsp_rd_data  out  32  read data (shared bus)
rsp_rd_valid  out  NREQ  one-hot read data strobe
rsp_done  out  NREQ  one-hot transaction complete pulse
busy  out  1  arbiter not in ARB
grant_id  out  IDW  current/last owner index
m_valid, m_rw  out  1  to master valid, rw
m_slave_addr  out  7  to master
m_addr, m_wr_data  out  32  to master
m_i2aen  out  1; m_i2ac, m_i2dc  out  2  to master
m_stall  in  1  master stall (high whenever master not idle)
m_rd_data  in  32; m_rd_valid  in  1  from master

Behaviour:
- Reset: state ARB, all outputs 0, last_grant = NREQ-1 (requester 0 wins first), command regs 0.
- FSM states ARB, ISSUE, WAIT_START, BUSY, DONE.
- ARB: if any req_valid, winner = first set bit searching from last_grant+1 upward, with modulo-NREQ wrap.
  - req_ready[winner] asserts combinationally this cycle.
  - On the edge: capture the winner's fields into command regs, update grant_id and last_grant, go to ISSUE.
  - No request: stay in ARB, m_valid=0.
- ISSUE: m_valid=1.
  - m_stall=0: master accepts; go to WAIT_START.
  - m_stall=1 (master still busy): hold m_valid=1 and stay.
- WAIT_START: m_valid=0. m_stall=1 -> BUSY. No transition otherwise (master raises stall the cycle after accept).
- BUSY: m_valid=0. On m_stall=0 -> DONE.
- DONE: rsp_done[grant_id]=1 for exactly one cycle, then ARB. This leaves a minimum 1-cycle master idle gap between transactions.
- m_rw, m_slave_addr, m_addr, m_wr_data, m_i2aen, m_i2ac, m_i2dc:
  - driven from command regs, constant from ISSUE through DONE.
  - Required because the master reads i2aen/i2ac/i2dc live during the transaction.
- rsp_rd_data = m_rd_data (combinational).
- rsp_rd_valid[i] = m_rd_valid & (grant_id==i) & state in {WAIT_START, BUSY}; otherwise 0.
- m_rd_valid outside those states is dropped.
- busy = (state != ARB).
- Write transaction: no rsp_rd_valid, only rsp_done.
- Read transaction: rsp_rd_valid strictly precedes rsp_done.
- req_valid deasserted by a requester before req_ready: withdrawn, no effect.
- Requests arriving while busy wait; the owner cannot re-win until all other pending requesters have been served once.
- Async reset mid-transaction: arbiter returns to ARB with m_valid=0. The master is reset by the same hresetn.

Optional Feature:
- I2C_ARB_FIXED_PRI_EN defined: winner = lowest-index asserted req_valid; last_grant is ignored (still updated).
- Not defined: round-robin as above.
- All other timing is identical.

Test Plan:
- Single write: req0 rw=1, sa=0x50, i2aen=1, i2ac=0, addr=0x12, i2dc=0, wr_data=0xA5 -> req_ready[0] one cycle; m_* stable until stall falls; rsp_done[0] one cycle; rsp_rd_valid never.
- Single read: req2 rw=0, sa=0x3C, i2ac=1, i2dc=3, slave model returns 0xDEADBEEF -> rsp_rd_valid[2] with rsp_rd_data=0xDEADBEEF, then rsp_done[2].
- Contention: all 4 req_valid from reset -> grant order 0,1,2,3. Req0 re-requests immediately -> order 0,1,2,3,0; no overlap of m_valid with busy master.
- Wrap: last_grant=3, req1 and req3 pending -> req1 wins next.
- Fixed priority (I2C_ARB_FIXED_PRI_EN): req0 kept asserted continuously with req3 -> req0 always wins.
- Reset mid-BUSY: drop hresetn during data byte -> all outputs 0, state ARB. After release, pending req1 is served normally.
